nes_pad_emulator: RTL and testbench

Device side of the NES controller serial interface: a cycle-accurate model of the pad's 4021 shift register that responds to `latch` / `pad_clock` and drives the serial `data` line. It sits wherever a real pad would: in the bench against `controller`, in on-chip loopback, or driven by a CPU/AI player into a `controller` instance. It synchronizes both strobes, tracks the 8-bit frame, and flags completed and aborted frames.

---
 rtl/nes_pad_pkg.sv | 25 ++
 rtl/nes_pad_emulator_if.sv | 23 ++
 rtl/nes_pad_emulator_sync_edge.sv | 29 ++
 rtl/nes_pad_emulator.sv | 162 ++++++++++++++++
 tb/tb_nes_pad_emulator.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad serial interface: button bit positions,
// frame geometry and the pad emulator state encoding.
package nes_pad_pkg;

    localparam int unsigned BTN_W      = 8;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned FRAME_BITS = 8;

    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } pad_state_e;

endpackage

// File: rtl/nes_pad_emulator_if.sv
// Pad-side bundle: host strobes and serial data, button inputs, frame status.
interface nes_pad_emulator_if;
    import nes_pad_pkg::*;

    logic [BTN_W-1:0] buttons;
    logic             latch;
    logic             pad_clock;
    logic             data;
    logic             frame_done;
    logic             frame_abort;
    logic [IDX_W-1:0] bit_index;

    modport master (
        output buttons, latch, pad_clock,
        input  data, frame_done, frame_abort, bit_index
    );

    modport slave (
        input  buttons, latch, pad_clock,
        output data, frame_done, frame_abort, bit_index
    );

endinterface

// File: rtl/nes_pad_emulator_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a rise/fall
// detector; edges appear on the _c outputs STAGES cycles after the input moves.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/nes_pad_emulator.sv
// Device-side model of the NES pad 4021 shift register: answers latch/pad_clock
// from the host, drives the serial data line and reports frame completion/abort.
module nes_pad_emulator
    import nes_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic        TAIL_BIT       = 1'b1,
    parameter bit          INVERT         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    nes_pad_emulator_if.slave  pad
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic        RELEASED = INVERT ? 1'b1 : 1'b0;

    logic latch_rise_c, latch_fall_c;
    logic clk_rise_c, clk_fall_c;
    logic any_edge_c;

    pad_state_e        state_q, state_n;
    logic [BTN_W-1:0]  sr_q, sr_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [TMO_W-1:0]  tmo_q, tmo_n;
    logic              done_evt_q, done_evt_n;
    logic              abort_evt_q, abort_evt_n;

    logic [SYNC_STAGES-1:0][BTN_W-1:0] btn_sync_q;
    logic [BTN_W-1:0]                  btn_sync;

    logic data_q;
    logic frame_done_q;
    logic frame_abort_q;

    sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pad.latch),
        .rise_c   (latch_rise_c),
        .fall_c   (latch_fall_c)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_clock_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pad.pad_clock),
        .rise_c   (clk_rise_c),
        .fall_c   (clk_fall_c)
    );

    assign any_edge_c = latch_rise_c | latch_fall_c | clk_rise_c | clk_fall_c;

    // Buttons share the strobe latency so the word frozen at latch fall
    // matches what the host saw on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_q <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], pad.buttons};
        end
    end

    assign btn_sync = btn_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            done_evt_q  <= 1'b0;
            abort_evt_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            sr_q        <= sr_n;
            idx_q       <= idx_n;
            tmo_q       <= tmo_n;
            done_evt_q  <= done_evt_n;
            abort_evt_q <= abort_evt_n;
        end
    end

    // Latch rise pre-empts everything, including a coincident clock edge.
    always_comb begin
        state_n     = state_q;
        sr_n        = sr_q;
        idx_n       = idx_q;
        tmo_n       = tmo_q;
        done_evt_n  = 1'b0;
        abort_evt_n = 1'b0;

        if (latch_rise_c) begin
            state_n     = LOAD;
            idx_n       = '0;
            tmo_n       = '0;
            abort_evt_n = (state_q == SHIFT) && (idx_q < IDX_W'(FRAME_BITS));
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_n = '0;
                end
                LOAD: begin
                    tmo_n = '0;
                    if (latch_fall_c) begin
                        state_n = SHIFT;
                    end else begin
                        sr_n = btn_sync;
                    end
                end
                SHIFT: begin
                    if (clk_rise_c) begin
                        sr_n  = {sr_q[BTN_W-2:0], TAIL_BIT};
                        idx_n = idx_q + IDX_W'(1);
                        tmo_n = '0;
                        if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
                            done_evt_n = 1'b1;
                            state_n    = DONE;
                        end
                    end else if (any_edge_c) begin
                        tmo_n = '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_evt_n = 1'b1;
                        state_n     = IDLE;
                        tmo_n       = '0;
                    end else begin
                        tmo_n = tmo_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    tmo_n = '0;
                    if (clk_rise_c) begin
                        sr_n = {sr_q[BTN_W-2:0], TAIL_BIT};
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Output stage: one cycle behind the FSM so pulses line up with data.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q        <= RELEASED;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            data_q        <= (state_q == IDLE) ? RELEASED : (sr_q[BTN_W-1] ^ INVERT);
            frame_done_q  <= done_evt_q;
            frame_abort_q <= abort_evt_q;
        end
    end

    assign pad.data        = data_q;
    assign pad.frame_done  = frame_done_q;
    assign pad.frame_abort = frame_abort_q;
    assign pad.bit_index   = idx_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Self-checking bench for nes_pad_emulator: random button frames read back
// serially against a bit-list model of what a real pad presents.
module tb_nes_pad_emulator;
    import nes_pad_pkg::*;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned TMO   = 20000;
    localparam int unsigned PHASE = 6;
    localparam bit          INV   = 1'b1;
    localparam logic        TAIL  = 1'b1;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    nes_pad_emulator_if pad_if ();

    nes_pad_emulator #(
        .SYNC_STAGES    (SYNC),
        .TAIL_BIT       (TAIL),
        .INVERT         (INV),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad_if)
    );

    always #5 clk = ~clk;

    // Every high cycle of a pulse output is counted, so stuck pulses overcount.
    always @(negedge clk) begin
        if (pad_if.frame_done)  done_cnt++;
        if (pad_if.frame_abort) abort_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wire level a genuine pad shows after k shifts of a frame latched from btn.
    function automatic logic exp_data(input logic [7:0] btn, input int k);
        logic b;
        b = (k < 8) ? btn[7 - k] : TAIL;
        return b ^ INV;
    endfunction

    task automatic pad_pulse();
        pad_if.pad_clock = 1'b1;
        tick(PHASE);
        pad_if.pad_clock = 1'b0;
        tick(PHASE);
    endtask

    task automatic run_frame(input logic [7:0] btn, input int exp_abort);
        int d0;
        int a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        pad_if.buttons = btn;
        pad_if.latch   = 1'b1;
        tick(12);
        check_eq("latch_idx", 32'(pad_if.bit_index), 0);
        pad_if.latch = 1'b0;
        tick(PHASE);
        pad_if.buttons = 8'($urandom);
        check_eq("bit0", 32'(pad_if.data), 32'(exp_data(btn, 0)));
        for (int k = 1; k <= 10; k++) begin
            pad_pulse();
            check_eq($sformatf("bit%0d", k), 32'(pad_if.data), 32'(exp_data(btn, k)));
            if (k == 8) begin
                check_eq("idx_full", 32'(pad_if.bit_index), 8);
                check_eq("done_once", 32'(done_cnt - d0), 1);
            end
        end
        check_eq("done_after_tail", 32'(done_cnt - d0), 1);
        check_eq("idx_sat", 32'(pad_if.bit_index), 8);
        check_eq("abort_cnt", 32'(abort_cnt - a0), 32'(exp_abort));
    endtask

    initial begin
        logic [7:0] b;
        int d0;
        int a0;
        int n;

        reset            = 1'b1;
        pad_if.latch     = 1'b0;
        pad_if.pad_clock = 1'b0;
        pad_if.buttons   = 8'h00;
        tick(3);
        check_eq("rst_data", 32'(pad_if.data), 1);
        check_eq("rst_idx", 32'(pad_if.bit_index), 0);
        check_eq("rst_done", 32'(pad_if.frame_done), 0);
        check_eq("rst_abort", 32'(pad_if.frame_abort), 0);
        reset = 1'b0;
        tick(2);

        run_frame(8'h81, 0);
        for (int i = 0; i < 5; i++) begin
            run_frame(8'($urandom), 0);
        end

        // Latch arriving mid-frame aborts it and restarts cleanly.
        pad_if.buttons = 8'($urandom);
        pad_if.latch   = 1'b1;
        tick(12);
        pad_if.latch = 1'b0;
        tick(PHASE);
        repeat (3) pad_pulse();
        check_eq("mid_idx", 32'(pad_if.bit_index), 3);
        run_frame(8'h40, 1);

        // Transparent load: data follows A while latch is held.
        b              = 8'h00;
        pad_if.buttons = b;
        pad_if.latch   = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++) begin
            logic old_d;
            old_d = exp_data(b, 0);
            b = {~b[7], 7'($urandom)};
            pad_if.buttons = b;
            tick(SYNC + 1);
            check_eq("live_old", 32'(pad_if.data), 32'(old_d));
            tick(1);
            check_eq("live_new", 32'(pad_if.data), 32'(exp_data(b, 0)));
            tick(16);
        end
        pad_pulse();
        pad_pulse();
        check_eq("load_ignores_clk", 32'(pad_if.bit_index), 0);

        // Timeout with no clocks after latch fall.
        a0 = abort_cnt;
        d0 = done_cnt;
        pad_if.latch = 1'b0;
        n = 0;
        while (!pad_if.frame_abort && n < int'(TMO) + 100) begin
            tick(1);
            n++;
        end
        check_eq("tmo_latency", 32'(n), 32'(TMO + SYNC + 2));
        check_eq("tmo_data", 32'(pad_if.data), 1);
        tick(2);
        check_eq("tmo_abort_once", 32'(abort_cnt - a0), 1);
        check_eq("tmo_no_done", 32'(done_cnt - d0), 0);

        // Reset in the middle of a frame.
        b              = 8'($urandom) | 8'h04;
        pad_if.buttons = b;
        pad_if.latch   = 1'b1;
        tick(12);
        pad_if.latch = 1'b0;
        tick(PHASE);
        repeat (5) pad_pulse();
        check_eq("pre_rst_idx", 32'(pad_if.bit_index), 5);
        check_eq("pre_rst_data", 32'(pad_if.data), 32'(exp_data(b, 5)));
        d0 = done_cnt;
        a0 = abort_cnt;
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_data", 32'(pad_if.data), 1);
        check_eq("mid_rst_idx", 32'(pad_if.bit_index), 0);
        check_eq("mid_rst_done", 32'(pad_if.frame_done), 0);
        check_eq("mid_rst_abort", 32'(pad_if.frame_abort), 0);
        tick(4);
        reset = 1'b0;
        tick(3);
        check_eq("rst_no_pulse", 32'((done_cnt - d0) + (abort_cnt - a0)), 0);

        run_frame(8'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
